// File: rtl/i2s_dac_tx.sv
// I2S transmitter: one mono sample per LRCLK frame, sent on both L and R
// slots, MSB first after the one-BCLK I2S delay, zero-padded to slot end.
module i2s_dac_tx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              bclk_negedge,
  input  logic              lrclk_negedge,
  input  logic              lrclk_posedge,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_audio,
  output logic              o_ready,
  output logic              o_dacdat,
  output logic              o_underflow,
  output logic              o_overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dacdat_d;
  logic                underflow_d;
  logic                overrun_d;

  // Holding and frame register update; frame loads at the left slot start.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    underflow_d = 1'b0;
    overrun_d   = 1'b0;
    if (lrclk_negedge) begin
      if (hold_full_q) begin
        frame_d = hold_q;
        if (i_valid) begin
          hold_d = i_audio;
        end else begin
          hold_full_d = 1'b0;
        end
      end else if (i_valid) begin
        frame_d = i_audio;
      end else begin
        frame_d     = '0;
        underflow_d = 1'b1;
      end
    end else if (i_valid) begin
      hold_d      = i_audio;
      hold_full_d = 1'b1;
      overrun_d   = hold_full_q;
    end
  end

  // Slot sequencer: LRCLK strobes restart a slot, BCLK falls advance it.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    dacdat_d = o_dacdat;
    if (lrclk_negedge) begin
      state_d  = DELAY;
      shift_d  = frame_d;
      dacdat_d = 1'b0;
    end else if (lrclk_posedge && (state_q != IDLE)) begin
      state_d  = DELAY;
      shift_d  = frame_q;
      dacdat_d = 1'b0;
    end else if (bclk_negedge) begin
      case (state_q)
        DELAY: begin
          dacdat_d = shift_q[DATA_W-1];
          shift_d  = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d    = CNT_W'(DATA_W - 1);
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            dacdat_d = 1'b0;
            state_d  = PAD;
          end else begin
            dacdat_d = shift_q[DATA_W-1];
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d    = cnt_q - CNT_W'(1);
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      o_dacdat    <= 1'b0;
      o_ready     <= 1'b1;
      o_underflow <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      o_dacdat    <= dacdat_d;
      o_ready     <= ~hold_full_d;
      o_underflow <= underflow_d;
      o_overrun   <= overrun_d;
    end
  end

endmodule
